if_fetch: RTL and testbench

Instruction-fetch stage that sits ahead of the decode stage. It fetches 32-bit RISC-V instructions over the shared byte-wide synchronous memory port and assembles them little-endian. It presents pc_o/inst_o/inst_valid_o to the IF/ID boundary, holding them under stall_i, and redirects to a new PC when a branch resolves. It keeps a one-entry holding buffer so a complete fetch is never lost while the output is stalled.

---
 rtl/if_fetch.sv | 143 ++++++++++++++
 tb/tb_if_fetch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: fetches 32-bit instructions one byte per cycle over
// a shared byte-wide synchronous memory port, assembles them little-endian and
// presents them to decode. A one-entry holding buffer keeps a completed fetch
// while the output is stalled; a branch redirect flushes everything in flight.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        mem_busy_i,
    input  logic [7:0]  mem_din_i,
    output logic [31:0] mem_a_o,
    output logic        mem_rd_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    logic [31:0]     pc_q, pc_d;
    logic [2:0]      iss_q, iss_d;
    logic [2:0]      rcv_q, rcv_d;
    logic            rd_q, rd_d;
    logic [2:0][7:0] byte_q, byte_d;
    logic            buf_valid_q, buf_valid_d;
    logic [31:0]     buf_pc_q, buf_pc_d;
    logic [31:0]     buf_inst_q, buf_inst_d;
    logic [31:0]     out_pc_q, out_pc_d;
    logic [31:0]     out_inst_q, out_inst_d;
    logic            out_valid_q, out_valid_d;

    logic        issue;
    logic        complete;
    logic        consume;
    logic        out_free;
    logic [31:0] word;

    // Memory request: one byte per cycle while the word is incomplete and the buffer is empty
    always_comb begin
        issue    = !rst && !branch_flag_i && !mem_busy_i && (iss_q < 3'd4) && !buf_valid_q;
        mem_rd_o = issue;
        mem_a_o  = rst ? RESET_PC : pc_q + 32'(iss_q);
    end

    // Next-state: byte capture, word completion, output/buffer handoff, branch flush
    always_comb begin
        pc_d        = pc_q;
        iss_d       = iss_q;
        rcv_d       = rcv_q;
        rd_d        = rd_q;
        byte_d      = byte_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_valid_d = out_valid_q;

        complete = rd_q && (rcv_q == 3'd3);
        word     = {mem_din_i, byte_q[2], byte_q[1], byte_q[0]};
        consume  = out_valid_q && !stall_i;
        out_free = !out_valid_q || !stall_i;

        if (branch_flag_i) begin
            // Clearing rd_q drops the byte still in flight from before the redirect
            pc_d        = branch_target_i;
            iss_d       = '0;
            rcv_d       = '0;
            rd_d        = 1'b0;
            buf_valid_d = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            rd_d = issue;
            if (issue) begin
                iss_d = iss_q + 3'd1;
            end
            if (rd_q && !complete) begin
                byte_d[rcv_q[1:0]] = mem_din_i;
                rcv_d              = rcv_q + 3'd1;
            end
            if (complete) begin
                pc_d  = pc_q + 32'd4;
                iss_d = '0;
                rcv_d = '0;
            end

            // Issue is blocked while the buffer is full, so a completion never
            // coincides with a buffer drain.
            if (consume && buf_valid_q) begin
                out_pc_d    = buf_pc_q;
                out_inst_d  = buf_inst_q;
                out_valid_d = 1'b1;
                buf_valid_d = 1'b0;
            end else if (complete && out_free) begin
                out_pc_d    = pc_q;
                out_inst_d  = word;
                out_valid_d = 1'b1;
            end else if (complete) begin
                buf_pc_d    = pc_q;
                buf_inst_d  = word;
                buf_valid_d = 1'b1;
            end else if (consume) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            iss_q       <= '0;
            rcv_q       <= '0;
            rd_q        <= 1'b0;
            byte_q      <= '0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= '0;
            buf_inst_q  <= '0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            iss_q       <= iss_d;
            rcv_q       <= rcv_d;
            rd_q        <= rd_d;
            byte_q      <= byte_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign pc_o         = out_pc_q;
    assign inst_o       = out_inst_q;
    assign inst_valid_o = out_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed test-plan scenarios plus a long
// randomized run, all compared every cycle against a queue-based reference model.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_busy_i;
    logic [7:0]  mem_din_i;
    logic [31:0] mem_a_o;
    logic        mem_rd_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .mem_busy_i      (mem_busy_i),
        .mem_din_i       (mem_din_i),
        .mem_a_o         (mem_a_o),
        .mem_rd_o        (mem_rd_o),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    int          m_iss;
    logic [7:0]  m_got[$];
    bit          m_rdq;
    logic [7:0]  m_din;
    bit          m_bufv;
    logic [31:0] m_bpc, m_binst;
    bit          m_ov;
    logic [31:0] m_opc, m_oinst;

    // Last sampled DUT outputs, for directed cycle checks
    logic        obs_rd, obs_valid;
    logic [31:0] obs_a, obs_pc, obs_inst;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0:   return 8'h13;
            32'h1:   return 8'h05;
            32'h2:   return 8'h10;
            32'h3:   return 8'h00;
            32'h4:   return 8'h93;
            32'h5:   return 8'h05;
            32'h6:   return 8'h20;
            32'h7:   return 8'h00;
            32'h100: return 8'hB7;
            32'h101: return 8'h02;
            32'h102: return 8'h00;
            32'h103: return 8'h01;
            default: return 8'((a * 32'd2654435761) >> 24) ^ a[7:0];
        endcase
    endfunction

    function automatic void model_reset();
        m_pc    = RESET_PC;
        m_iss   = 0;
        m_got.delete();
        m_rdq   = 1'b0;
        m_bufv  = 1'b0;
        m_bpc   = '0;
        m_binst = '0;
        m_ov    = 1'b0;
        m_opc   = '0;
        m_oinst = '0;
    endfunction

    // One clock cycle: apply inputs, check outputs mid-cycle, advance model, return read data
    task automatic cycle(input bit r, input bit st, input bit br, input bit busy,
                         input logic [31:0] tgt);
        bit          exp_rd, done, accepted;
        logic [31:0] exp_a, word;
        rst             = r;
        stall_i         = st;
        branch_flag_i   = br;
        mem_busy_i      = busy;
        branch_target_i = tgt;
        @(negedge clk);
        exp_rd = !r && !br && !busy && (m_iss < 4) && !m_bufv;
        exp_a  = r ? RESET_PC : m_pc + 32'(m_iss);
        obs_rd = mem_rd_o; obs_a = mem_a_o; obs_valid = inst_valid_o;
        obs_pc = pc_o; obs_inst = inst_o;
        check("mem_rd_o", 32'(mem_rd_o), 32'(exp_rd));
        check("mem_a_o", mem_a_o, exp_a);
        check("inst_valid_o", 32'(inst_valid_o), 32'(m_ov));
        check("pc_o", pc_o, m_opc);
        check("inst_o", inst_o, m_oinst);

        if (r) begin
            model_reset();
        end else if (br) begin
            m_pc  = tgt;
            m_iss = 0;
            m_got.delete();
            m_rdq  = 1'b0;
            m_bufv = 1'b0;
            m_ov   = 1'b0;
        end else begin
            done     = m_rdq && (m_got.size() == 3);
            accepted = m_ov && !st;
            word     = '0;
            if (done) word = {m_din, m_got[2], m_got[1], m_got[0]};
            else if (m_rdq) m_got.push_back(m_din);
            if (exp_rd) m_iss++;
            m_rdq = exp_rd;
            if (done) begin
                m_pc  = m_pc + 32'd4;
                m_iss = 0;
                m_got.delete();
            end
            if (accepted && m_bufv) begin
                m_opc = m_bpc; m_oinst = m_binst; m_ov = 1'b1; m_bufv = 1'b0;
            end else if (done && (!m_ov || !st)) begin
                m_opc = m_pc - 32'd4; m_oinst = word; m_ov = 1'b1;
            end else if (done) begin
                m_bpc = m_pc - 32'd4; m_binst = word; m_bufv = 1'b1;
            end else if (accepted) begin
                m_ov = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        m_din     = exp_rd ? mem_byte(exp_a) : 8'($urandom);
        mem_din_i = m_din;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        bit          st, br, busy, r;
        logic [31:0] tgt;
        rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; mem_busy_i = 1'b0;
        branch_target_i = '0; mem_din_i = '0; m_din = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Plain fetch of two instructions
        do_reset();
        check("reset_valid", 32'(obs_valid), 32'd0);
        check("reset_pc", obs_pc, 32'd0);
        for (int c = 0; c < 12; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
            if (c == 0) check("t1_addr0", obs_a, 32'd0);
            if (c == 4) check("t1_noissue4", 32'(obs_rd), 32'd0);
            if (c == 4) check("t1_notvalid4", 32'(obs_valid), 32'd0);
            if (c == 5) check("t1_addr5", obs_a, 32'd4);
            if (c == 5) check("t1_inst5", obs_inst, 32'h0010_0513);
            if (c == 5) check("t1_pc5", obs_pc, 32'd0);
            if (c == 6) check("t1_notvalid6", 32'(obs_valid), 32'd0);
            if (c == 10) check("t1_inst10", obs_inst, 32'h0020_0593);
            if (c == 10) check("t1_pc10", obs_pc, 32'd4);
            if (c == 10) check("t1_valid10", 32'(obs_valid), 32'd1);
        end

        // Memory busy in cycles 1-2
        do_reset();
        for (int c = 0; c < 9; c++) begin
            cycle(1'b0, 1'b0, 1'b0, (c == 1 || c == 2), '0);
            if (c == 3) check("t2_addr3", obs_a, 32'd1);
            if (c == 6) check("t2_notvalid6", 32'(obs_valid), 32'd0);
            if (c == 7) check("t2_valid7", 32'(obs_valid), 32'd1);
            if (c == 7) check("t2_inst7", obs_inst, 32'h0010_0513);
        end

        // Stall cycles 5..14: second instruction parks in the buffer
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cycle(1'b0, (c >= 5 && c <= 14), 1'b0, 1'b0, '0);
            if (c == 10) check("t3_noissue10", 32'(obs_rd), 32'd0);
            if (c == 15) check("t3_pc15", obs_pc, 32'd0);
            if (c == 15) check("t3_inst15", obs_inst, 32'h0010_0513);
            if (c == 16) check("t3_pc16", obs_pc, 32'd4);
            if (c == 16) check("t3_valid16", 32'(obs_valid), 32'd1);
        end

        // Branch to 0x100 in cycle 2
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 1'b0, (c == 2), 1'b0, 32'h100);
            if (c == 3) check("t4_addr3", obs_a, 32'h100);
            if (c == 5) check("t4_notvalid5", 32'(obs_valid), 32'd0);
            if (c == 8) check("t4_inst8", obs_inst, 32'h0100_02B7);
            if (c == 8) check("t4_pc8", obs_pc, 32'h100);
        end

        // Branch while stalled with a full buffer
        do_reset();
        for (int c = 0; c < 22; c++) begin
            cycle(1'b0, (c >= 5 && c <= 12), (c == 12), 1'b0, 32'h100);
            if (c == 13) check("t5_flush13", 32'(obs_valid), 32'd0);
            if (c == 18) check("t5_pc18", obs_pc, 32'h100);
        end

        // Reset pulse in cycle 3
        do_reset();
        for (int c = 0; c < 11; c++) begin
            cycle((c == 3), 1'b0, 1'b0, 1'b0, '0);
            if (c == 4) check("t6_inst4", obs_inst, 32'd0);
            if (c == 8) check("t6_notvalid8", 32'(obs_valid), 32'd0);
            if (c == 9) check("t6_valid9", 32'(obs_valid), 32'd1);
            if (c == 9) check("t6_pc9", obs_pc, RESET_PC);
        end

        // Randomized traffic, including misaligned and wrapping branch targets
        for (int c = 0; c < 3000; c++) begin
            st   = ($urandom_range(99) < 30);
            busy = ($urandom_range(99) < 25);
            br   = ($urandom_range(99) < 3);
            r    = ($urandom_range(999) < 5);
            if ($urandom_range(2) == 0) tgt = 32'hFFFF_FFF8 + 32'($urandom_range(7));
            else tgt = $urandom;
            cycle(r, st, br, busy, tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
